// File: rtl/serial_adder_core_if.sv
// Operand/result handshake bundle for serial_adder_core.
// The master side presents operands and takes results; the core is the slave.
interface serial_adder_core_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             carry_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;
  logic             busy;

  modport master (
    output in_valid, a, b, sub, carry_in, out_ready,
    input  in_ready, out_valid, sum, carry_out, overflow, busy
  );

  modport slave (
    input  in_valid, a, b, sub, carry_in, out_ready,
    output in_ready, out_valid, sum, carry_out, overflow, busy
  );
endinterface

// File: rtl/serial_adder_core.sv
// Digit-serial add/subtract: DIGIT bits per clock, WIDTH/DIGIT cycles per
// operation, valid/ready on both sides, with carry-out and signed overflow.
module serial_adder_core #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_adder_core_if.slave   io
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_adder_core: DIGIT must divide WIDTH exactly");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     a_sh, b_sh, res_sh, sum_r;
  logic                 cy, co_r, ov_r;
  logic [CW-1:0]        cnt;
  logic [DIGIT:0]       dsum;
  logic [WIDTH+DIGIT-1:0] res_cat;
  logic                 last, accept, msb_cin;

  always_comb begin
    dsum    = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + {{DIGIT{1'b0}}, cy};
    res_cat = {dsum[DIGIT-1:0], res_sh};
    last    = (cnt == CW'(N - 1));
    accept  = (state == IDLE) && io.in_valid;
    // Carry into the top bit of this digit, recovered from its sum bit;
    // only meaningful on the final digit where it is the carry into the MSB.
    msb_cin = a_sh[DIGIT-1] ^ b_sh[DIGIT-1] ^ dsum[DIGIT-1];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (io.in_valid) state_nxt = RUN;
      RUN:     if (last)        state_nxt = DONE;
      DONE:    if (io.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      cy     <= 1'b0;
      cnt    <= '0;
      sum_r  <= '0;
      co_r   <= 1'b0;
      ov_r   <= 1'b0;
    end else if (accept) begin
      // Subtract is a + ~b + ~borrow_in, so both are inverted once here.
      a_sh <= io.a;
      b_sh <= io.sub ? ~io.b : io.b;
      cy   <= io.sub ^ io.carry_in;
      cnt  <= '0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> DIGIT;
      b_sh   <= b_sh >> DIGIT;
      res_sh <= res_cat[WIDTH+DIGIT-1:DIGIT];
      cy     <= dsum[DIGIT];
      cnt    <= cnt + CW'(1);
      if (last) begin
        sum_r <= res_cat[WIDTH+DIGIT-1:DIGIT];
        co_r  <= dsum[DIGIT];
        ov_r  <= msb_cin ^ dsum[DIGIT];
      end
    end
  end

  assign io.in_ready  = (state == IDLE);
  assign io.out_valid = (state == DONE);
  assign io.busy      = (state != IDLE);
  assign io.sum       = sum_r;
  assign io.carry_out = co_r;
  assign io.overflow  = ov_r;
endmodule

// File: tb/tb_serial_adder_core.sv
// Drives four cores (DIGIT = 2, 1, 4, 8) from one stimulus bus and checks
// each against an arithmetic reference model.
module tb_serial_adder_core;
  localparam int NI = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, sub, cin, out_ready;
  logic [7:0] a, b;

  logic       ir_a [NI];
  logic       ov_a [NI];
  logic       co_a [NI];
  logic       of_a [NI];
  logic       bz_a [NI];
  logic [7:0] sm_a [NI];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  function automatic int dig(int g);
    return (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 4 : 8;
  endfunction

  generate
    for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int D = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 4 : 8;
      serial_adder_core_if #(.WIDTH(8)) bus ();
      assign bus.in_valid  = in_valid;
      assign bus.a         = a;
      assign bus.b         = b;
      assign bus.sub       = sub;
      assign bus.carry_in  = cin;
      assign bus.out_ready = out_ready;
      assign ir_a[g] = bus.in_ready;
      assign ov_a[g] = bus.out_valid;
      assign co_a[g] = bus.carry_out;
      assign of_a[g] = bus.overflow;
      assign bz_a[g] = bus.busy;
      assign sm_a[g] = bus.sum;
      serial_adder_core #(.WIDTH(8), .DIGIT(D)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
      );
    end
  endgenerate

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic, returns {carry_out, overflow, sum}.
  function automatic logic [9:0] ref_op(logic [7:0] x, logic [7:0] y, logic s, logic c);
    int ux, uy, sx, sy, ci, r, sr;
    logic co, ov;
    ux = int'(x); uy = int'(y);
    sx = int'($signed(x)); sy = int'($signed(y));
    ci = c ? 1 : 0;
    if (!s) begin
      r  = ux + uy + ci;
      sr = sx + sy + ci;
      co = (r > 255);
    end else begin
      r  = ux - uy - ci;
      sr = sx - sy - ci;
      co = (ux >= uy + ci);
    end
    ov = (sr > 127) || (sr < -128);
    return {co, ov, 8'(r & 255)};
  endfunction

  function automatic logic all_ready();
    logic r = 1'b1;
    for (int g = 0; g < NI; g++) r &= ir_a[g];
    return r;
  endfunction

  function automatic logic any_valid();
    logic r = 1'b0;
    for (int g = 0; g < NI; g++) r |= ov_a[g];
    return r;
  endfunction

  // Issue one operation, measure each core's latency, check results, then
  // consume. Leaves all cores in DONE when hold is set.
  task automatic issue(input logic [7:0] ta, input logic [7:0] tb_, input logic ts,
                       input logic tc, input bit hold);
    logic [9:0] e;
    int lat [NI];
    int cyc;
    bit done;
    e = ref_op(ta, tb_, ts, tc);
    cyc = 0;
    while (!all_ready() && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (!all_ready()) chk("idle_wait", 0, 1);
    a = ta; b = tb_; sub = ts; cin = tc; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom); cin = 1'($urandom);
    chk("busy_after_accept", 32'(bz_a[0]), 1);
    for (int g = 0; g < NI; g++) lat[g] = -1;
    cyc = 0;
    done = 0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
      done = 1;
      for (int g = 0; g < NI; g++) begin
        if (ov_a[g] && lat[g] < 0) lat[g] = cyc;
        if (lat[g] < 0) done = 0;
      end
    end
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("lat_d%0d", dig(g)), 32'(lat[g]), 32'(8 / dig(g)));
      chk($sformatf("sum_d%0d", dig(g)), 32'(sm_a[g]), 32'(e[7:0]));
      chk($sformatf("co_d%0d", dig(g)),  32'(co_a[g]), 32'(e[9]));
      chk($sformatf("ov_d%0d", dig(g)),  32'(of_a[g]), 32'(e[8]));
    end
    if (!hold) begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("ready_after_take", 32'(ir_a[0]), 1);
      chk("sum_retained", 32'(sm_a[0]), 32'(e[7:0]));
    end
  endtask

  logic [7:0] da [5] = '{8'h7F, 8'hFF, 8'h05, 8'h80, 8'h10};
  logic [7:0] db [5] = '{8'h01, 8'h01, 8'h07, 8'h01, 8'h0F};
  logic       ds [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic       dc [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    logic [7:0] hs;
    logic       hc, hv;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; cin = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      chk("rst_in_ready",  32'(ir_a[g]), 1);
      chk("rst_out_valid", 32'(ov_a[g]), 0);
      chk("rst_busy",      32'(bz_a[g]), 0);
      chk("rst_sum",       32'(sm_a[g]), 0);
      chk("rst_flags",     32'({co_a[g], of_a[g]}), 0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Directed corner cases, then the A5+5A parameter sweep.
    for (int i = 0; i < 5; i++) issue(da[i], db[i], ds[i], dc[i], 1'b0);
    issue(8'hA5, 8'h5A, 1'b0, 1'b1, 1'b0);

    // Backpressure: result held while inputs churn, no second accept.
    issue(8'h3C, 8'h42, 1'b0, 1'b0, 1'b1);
    hs = sm_a[0]; hc = co_a[0]; hv = of_a[0];
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
      @(negedge clk);
      chk("bp_sum",       32'(sm_a[0]), 32'(hs));
      chk("bp_flags",     32'({co_a[0], of_a[0]}), 32'({hc, hv}));
      chk("bp_in_ready",  32'(ir_a[0]), 0);
      chk("bp_out_valid", 32'(ov_a[0]), 1);
    end
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    chk("bp_release_ready", 32'(ir_a[0]), 1);
    chk("bp_release_busy",  32'(bz_a[0]), 0);

    // Reset at RUN cycle 2 of the DIGIT=2 core.
    a = 8'h11; b = 8'h22; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int g = 0; g < NI; g++) begin
      chk("mid_rst_out_valid", 32'(ov_a[g]), 0);
      chk("mid_rst_busy",      32'(bz_a[g]), 0);
      chk("mid_rst_sum",       32'(sm_a[g]), 0);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("no_stale_result", 32'(any_valid()), 0);
    end
    issue(8'h03, 8'h04, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 1000; i++)
      issue(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_adder_core.md
Name: serial_adder_core

Overview:
- Parametrised multi-cycle adder/subtractor; successor to the single-shot combinational adder in the tile.
- Processes DIGIT bits per clock over WIDTH/DIGIT cycles and supports add or subtract with carry/borrow in.
- Uses valid/ready handshakes on both input and output, and reports carry-out and signed overflow.
- Sits between the tile's pin-mapping top level and the operand/result registers.

Parameters:
- WIDTH, 8, operand and result width in bits; must be ≥1.
- DIGIT, 2, bits processed per cycle; must divide WIDTH exactly (elaboration error otherwise).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand presented.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  0 = add, 1 = subtract; sampled with the operands.
- carry_in  input  1  carry in (add) or borrow in (sub); sampled with the operands.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- sum  output  WIDTH  result.
- carry_out  output  1  raw adder carry out of the MSB.
- overflow  output  1  two's-complement overflow.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (rst=1 at an edge):
  - State goes to IDLE; the digit counter clears.
  - sum, carry_out, overflow and out_valid go to 0; in_ready=1; busy=0.
  - Reset overrides every other input in the same cycle, including a mid-RUN operation. An aborted operation never produces out_valid.
- States: IDLE, RUN, DONE.
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE).
  - busy = (state!=IDLE).
- IDLE:
  - On in_valid & in_ready, latch A, B' and the carry register, clear the counter, and go to RUN.
  - B' = sub ? ~b : b.
  - Carry register = sub ? ~carry_in : carry_in.
  - The add result is a+b+carry_in; the sub result is a-b-carry_in (mod 2^WIDTH).
- RUN, each cycle:
  - Add the low DIGIT bits of A, B' and the carry register.
  - Shift the DIGIT-bit result into the top of the result shift register; shift A and B' right by DIGIT; update the carry register; increment the counter.
  - Record the carry into the MSB position during the final digit.
  - After exactly N = WIDTH/DIGIT RUN cycles, go to DONE, registering sum, carry_out and overflow.
- Result flags:
  - carry_out is the raw carry out of the MSB. For subtract, carry_out=1 means no borrow (a ≥ b+carry_in).
  - overflow = carry into MSB XOR carry out of MSB.
- Latency: operands accepted at edge k give out_valid=1 after edge k+N.
  - DIGIT=WIDTH gives latency 1.
  - DIGIT=1 gives latency WIDTH.
- DONE:
  - sum, carry_out and overflow stay stable while out_valid=1 and out_ready=0 (unbounded backpressure).
  - On out_ready=1, go to IDLE. The same cycle does not accept new operands because in_ready=0 in DONE.
- Operand handling outside IDLE:
  - in_valid is ignored in RUN and DONE; operands changing during RUN do not affect the result.
- Output retention:
  - After the result is consumed, sum, carry_out and overflow keep their last value until the next completion or reset.
- Back-to-back throughput: one result per N+2 cycles maximum (IDLE accept, N RUN cycles, DONE handoff).
- Wrap-around: the result is mod 2^WIDTH; no saturation.

Test Plan:
- WIDTH=8, DIGIT=2: add 0x7F+0x01, cin=0 -> sum=0x80, carry_out=0, overflow=1. out_valid rises exactly 4 cycles after the accept edge.
- Add 0xFF+0x01, cin=1 -> sum=0x01, carry_out=1, overflow=0. Sub 0x05-0x07, cin=0 -> sum=0xFE, carry_out=0, overflow=0.
- Sub 0x80-0x01, cin=0 -> sum=0x7F, carry_out=1, overflow=1. Sub 0x10-0x0F, cin=1 -> sum=0x00, carry_out=1, overflow=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid, a and b.
  - Required: sum and flags stable, in_ready=0, no second accept.
  - After out_ready=1: IDLE with in_ready=1 on the next cycle.
- Reset mid-RUN: assert rst for 1 cycle at RUN cycle 2.
  - Required: next cycle IDLE, out_valid=0, busy=0, sum=0; no stale result appears later.
  - A fresh 0x03+0x04 then yields 0x07.
- Parameter sweep: repeat 0xA5+0x5A, cin=1 (-> 0x00, carry_out=1) with DIGIT=1, 4 and 8.
  - Required latency: 8, 2 and 1 cycles respectively.
  - Randomised 1000-vector check against a reference model, both modes.
